// File: rtl/instr_feed_unit.sv
// instr_feed_unit
//   Feeds instruction words from a small program memory into a multicycle
//   processor. One Run pulse goes out per issued instruction. An mvi also
//   presents its immediate word. The unit then waits for Done, or raises
//   Error if Done does not arrive within TIMEOUT wait cycles.
//
//   Ports
//     Clock       single clock, all state changes on its rising edge
//     Reset       synchronous active-high reset (program memory is kept)
//     Start       begin execution at address 0 (from IDLE, HALT or ERROR)
//     LoadEn      program-memory write enable (honoured in IDLE/HALT/ERROR)
//     LoadAddr    program-memory write address
//     LoadData    program-memory write data
//     Done        instruction-complete strobe from the processor
//     DIN         instruction / immediate word to the processor
//     Run         one-cycle run strobe per issued instruction
//     PC          current program-memory address
//     Busy        high in ISSUE, IMM, WAIT
//     Halted      high in HALT
//     Error       high in ERROR
//     InstrCount  Run pulses since the last Start, saturating at 255
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | out of reset, nothing running, memory writable
//   ISSUE  | present mem[PC]: halt opcode -> HALT, else pulse Run
//   IMM    | present the mvi immediate word at mem[PC]
//   WAIT   | hold last word on DIN, wait for Done with timeout
//   HALT   | halt opcode reached, memory writable, Start restarts
//   ERROR  | Done never arrived, memory writable, Start restarts

module instr_feed_unit #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [15:0]       LoadData,
  input  logic              Done,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        InstrCount
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Timeout is a down-counter: loaded on WAIT entry, decremented on each
  // Done-less WAIT cycle. The WAIT cycle that finds it at zero is the
  // TIMEOUT-th such cycle.
  localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
  localparam logic [2:0]        OP_MVI   = 3'b001;
  localparam logic [2:0]        OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        icnt_q, icnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [15:0]       hold_q, hold_d;

  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       rd_word;
  logic [2:0]        rd_op;
  logic              mem_we;

  assign rd_word = mem_q[pc_q];
  assign rd_op   = rd_word[8:6];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    icnt_d  = icnt_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    DIN     = 16'h0000;
    Run     = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        mem_we = LoadEn;
        if (Start) begin
          pc_d    = '0;
          icnt_d  = 8'h00;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (rd_op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          DIN    = rd_word;
          Run    = 1'b1;
          hold_d = rd_word;
          pc_d   = pc_q + PC_ONE;
          if (icnt_q != 8'hFF) begin
            icnt_d = icnt_q + 8'd1;
          end
          if (rd_op == OP_MVI) begin
            state_d = S_IMM;
          end else begin
            state_d = S_WAIT;
            tmo_d   = TMO_LOAD;
          end
        end
      end

      S_IMM: begin
        // The immediate sits at the already-incremented PC, so an mvi at
        // the top address fetches its immediate from address 0.
        DIN    = rd_word;
        hold_d = rd_word;
        pc_d   = pc_q + PC_ONE;
        if (Done) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
          tmo_d   = TMO_LOAD;
        end
      end

      S_WAIT: begin
        DIN = hold_q;
        if (Done) begin
          state_d = S_ISSUE;
        end else if (tmo_q == '0) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q - TMO_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      icnt_q  <= 8'h00;
      tmo_q   <= '0;
      hold_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      icnt_q  <= icnt_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
    end
  end

  // Program memory has no reset so a program survives Reset; a write in
  // the reset cycle is dropped.
  always_ff @(posedge Clock) begin
    if (!Reset && mem_we) begin
      mem_q[LoadAddr] <= LoadData;
    end
  end

  assign PC         = pc_q;
  assign InstrCount = icnt_q;
  assign Busy       = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);
  assign Halted     = (state_q == S_HALT);
  assign Error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_instr_feed_unit.sv
module tb_instr_feed_unit;

  localparam int AW = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic          LoadEn;
  logic [AW-1:0] LoadAddr;
  logic [15:0]   LoadData;
  logic          Done;
  logic [15:0]   DIN;
  logic          Run;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Halted;
  logic          Error;
  logic [7:0]    InstrCount;

  instr_feed_unit #(.ADDR_W(AW), .TIMEOUT(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .LoadEn(LoadEn),
    .LoadAddr(LoadAddr), .LoadData(LoadData), .Done(Done),
    .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted),
    .Error(Error), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  localparam int K_RUN  = 0;
  localparam int K_HALT = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int din;
    int pc;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   done_delay = 0;
  int   cd = 0;
  logic halted_prev = 1'b0;
  logic error_prev  = 1'b0;
  logic [15:0] prog_e [4] = '{16'h0001, 16'h00C8, 16'h0112, 16'h1283};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int din, input int pc, input int cnt);
    exp_t e;
    e.kind = kind; e.din = din; e.pc = pc; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic evt(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL evt_unexpected: kind %0d pc 0x%0h din 0x%0h, expected no event (t=%0t)",
               kind, PC, DIN, $time);
    end else begin
      e = q.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_din", int'(DIN), e.din);
      chk("evt_pc", int'(PC), e.pc);
      chk("evt_count", int'(InstrCount), e.cnt);
    end
  endtask

  // Scoreboard monitor: Run pulses and Halted/Error rising edges.
  always @(negedge Clock) begin
    if (Run === 1'b1) evt(K_RUN);
    if (Halted === 1'b1 && halted_prev !== 1'b1) evt(K_HALT);
    if (Error === 1'b1 && error_prev !== 1'b1) evt(K_ERR);
    halted_prev <= Halted;
    error_prev  <= Error;
  end

  // Processor model: Done for one cycle, done_delay cycles after Run.
  initial begin
    Done = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      Done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) Done = 1'b1;
      end
      if (Run === 1'b1 && done_delay > 0) cd = done_delay;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    LoadEn = 1'b1; LoadAddr = AW'(a); LoadData = d;
    tick();
    LoadEn = 1'b0;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_q(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, q.size(), 0);
    if (q.size() != 0) q.delete();
  endtask

  // Drain expected Runs, then stop the processor model before it can
  // answer the last one.
  task automatic drain_stop(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge Clock);
      #1;
      n++;
    end
    done_delay = 0;
    cd = 0;
    chk({name, "_drained"}, q.size(), 0);
    if (q.size() != 0) q.delete();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before t=200000");
    $fatal(1);
  end

  initial begin
    int n;
    int run_in_wait;
    Reset = 1'b1; Start = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
    tick();
    tick();
    chk("rst_din", int'(DIN), 0);
    chk("rst_run", int'(Run), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_halted_error", int'({Halted, Error}), 0);
    chk("rst_pc", int'(PC), 0);
    chk("rst_count", int'(InstrCount), 0);
    Reset = 1'b0;

    // mvi with Done right after Run, then halt
    wr(0, 16'h0040); wr(1, 16'h0005); wr(2, 16'h01C0);
    done_delay = 1;
    push(K_RUN, 16'h0040, 0, 0);
    push(K_HALT, 0, 2, 1);
    start_pulse();
    chk("a_busy_issue", int'(Busy), 1);
    tick();
    chk("a_imm_din", int'(DIN), 16'h0005);
    chk("a_imm_run", int'(Run), 0);
    chk("a_imm_pc", int'(PC), 1);
    wait_q("a", 20);
    chk("a_halted", int'(Halted), 1);
    chk("a_pc", int'(PC), 2);

    // single-word instruction, Done three cycles after Run
    wr(0, 16'h00C8); wr(1, 16'h01C0);
    done_delay = 3;
    push(K_RUN, 16'h00C8, 0, 0);
    push(K_HALT, 0, 1, 1);
    start_pulse();
    tick();
    chk("b_wait_din1", int'(DIN), 16'h00C8);
    chk("b_wait_run", int'(Run), 0);
    tick();
    chk("b_wait_din2", int'(DIN), 16'h00C8);
    wait_q("b", 20);
    chk("b_count", int'(InstrCount), 1);

    // no Done -> timeout
    wr(0, 16'h0001);
    done_delay = 0;
    push(K_RUN, 16'h0001, 0, 0);
    push(K_ERR, 0, 1, 1);
    start_pulse();
    tick();
    n = 0;
    run_in_wait = 0;
    while (Error !== 1'b1 && n < 40) begin
      if (Run !== 1'b0) run_in_wait = 1;
      tick();
      n++;
    end
    chk("c_timeout_cycles", n, 16);
    chk("c_run_in_wait", run_in_wait, 0);
    wait_q("c", 5);

    // reset during WAIT, memory survives
    push(K_RUN, 16'h0001, 0, 0);
    start_pulse();
    tick();
    tick();
    chk("d_busy_before", int'(Busy), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("d_busy", int'(Busy), 0);
    chk("d_run", int'(Run), 0);
    chk("d_din", int'(DIN), 0);
    chk("d_pc", int'(PC), 0);
    chk("d_count", int'(InstrCount), 0);
    chk("d_halted_error", int'({Halted, Error}), 0);
    push(K_RUN, 16'h0001, 0, 0);
    start_pulse();
    wait_q("d_readback", 5);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;

    // load and Start while busy are ignored; load in HALT works
    for (int i = 0; i < 4; i++) wr(i, prog_e[i]);
    wr(4, 16'h01C0);
    done_delay = 2;
    for (int i = 0; i < 4; i++) push(K_RUN, prog_e[i], i, i);
    push(K_HALT, 0, 4, 4);
    start_pulse();
    chk("e_busy", int'(Busy), 1);
    Start = 1'b1;
    LoadEn = 1'b1; LoadAddr = '0; LoadData = 16'h01C0;
    tick();
    tick();
    LoadEn = 1'b0;
    tick();
    tick();
    Start = 1'b0;
    wait_q("e_first", 40);
    for (int i = 0; i < 4; i++) push(K_RUN, prog_e[i], i, i);
    push(K_HALT, 0, 4, 4);
    start_pulse();
    wait_q("e_rerun", 40);
    wr(0, 16'h01C0);
    push(K_HALT, 0, 0, 0);
    start_pulse();
    wait_q("e_halt_write", 10);
    chk("e_pc", int'(PC), 0);

    // all single-word: PC wraps, count saturates
    for (int i = 0; i < 32; i++) wr(i, 16'h0001);
    done_delay = 1;
    for (int i = 0; i < 260; i++) push(K_RUN, 16'h0001, i % 32, (i < 255) ? i : 255);
    start_pulse();
    drain_stop("g", 700);
    chk("g_count_sat", int'(InstrCount), 255);
    push(K_ERR, 0, 4, 255);
    wait_q("g_err", 40);

    // mvi at the top address takes its immediate from address 0
    wr(31, 16'h0040);
    done_delay = 1;
    for (int i = 0; i < 31; i++) push(K_RUN, 16'h0001, i, i);
    push(K_RUN, 16'h0040, 31, 31);
    push(K_RUN, 16'h0001, 1, 32);
    start_pulse();
    drain_stop("f", 200);
    push(K_ERR, 0, 2, 33);
    wait_q("f_err", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_feed_unit.md
INSTR_FEED_UNIT -- requirements
Module: instr_feed_unit

Interface
REQ-001 Parameter ADDR_W, default 5, program-memory address width (depth 2^ADDR_W words).
REQ-002 Parameter TIMEOUT, default 16, maximum consecutive WAIT cycles without Done before error.
REQ-003 Clock  input  1  single clock; all state changes on posedge Clock.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  begin program execution at address 0.
REQ-006 LoadEn  input  1  program-memory write enable.
REQ-007 LoadAddr  input  ADDR_W  program-memory write address.
REQ-008 LoadData  input  16  program-memory write data.
REQ-009 Done  input  1  instruction-complete strobe from the multicycle processor.
REQ-010 DIN  output  16  instruction/immediate word driven to the processor DIN.
REQ-011 Run  output  1  processor run strobe; one-cycle pulse per issued instruction.
REQ-012 PC  output  ADDR_W  current program-memory address.
REQ-013 Busy  output  1  high in ISSUE, IMM, WAIT.
REQ-014 Halted  output  1  high in HALT.
REQ-015 Error  output  1  high in ERROR.
REQ-016 InstrCount  output  8  number of Run pulses issued since last Start, saturating at 255.

Function
REQ-017 Program memory SHALL be 2^ADDR_W x 16 registers, written at posedge when LoadEn=1 and state is IDLE, HALT or ERROR; LoadEn in other states SHALL be ignored; reads SHALL be combinational at PC.
REQ-018 Instruction format SHALL be word[8:0] = {III, XXX, YYY}; III=001 (mvi) consumes the next word as immediate; III=111 is HALT; all other opcodes are single-word.
REQ-019 FSM states SHALL be IDLE, ISSUE, IMM, WAIT, HALT, ERROR.
REQ-020 IDLE: DIN=0, Run=0; Start=1 -> PC<=0, InstrCount<=0, next ISSUE.
REQ-021 ISSUE with mem[PC][8:6]=111: Run=0, DIN=0, PC unchanged, next HALT.
REQ-022 ISSUE otherwise: DIN=mem[PC], Run=1 this cycle only, PC<=PC+1, InstrCount<=InstrCount+1 (saturating); next IMM if opcode 001, else WAIT.
REQ-023 IMM: DIN=mem[PC] (immediate), Run=0; Done=1 -> PC<=PC+1, next ISSUE; Done=0 -> PC<=PC+1, next WAIT with DIN held at the immediate.
REQ-024 WAIT: Run=0, DIN holds last driven word; Done=1 -> next ISSUE; Done=0 for TIMEOUT consecutive WAIT cycles -> next ERROR.
REQ-025 Timeout counter SHALL clear on every WAIT entry and count only WAIT cycles with Done=0.
REQ-026 PC increment SHALL wrap 2^ADDR_W-1 -> 0, including an mvi at the last address fetching its immediate from address 0.
REQ-027 HALT and ERROR: Run=0, DIN=0; Start=1 -> same action as IDLE Start; otherwise remain.
REQ-028 Start in ISSUE, IMM or WAIT SHALL be ignored.
REQ-029 Done in IDLE, HALT, ERROR or ISSUE SHALL be ignored.
REQ-030 DIN and Run SHALL be functions of registered state and PC only (no combinational path from Done or Start).

Reset
REQ-031 Reset=1 at posedge SHALL set state IDLE, PC=0, InstrCount=0, timeout counter=0; outputs DIN=0, Run=0, Busy=0, Halted=0, Error=0 from that edge.
REQ-032 Reset SHALL override Start, LoadEn and Done in the same cycle, SHALL abort any in-flight instruction, and SHALL NOT clear program memory.

Verification
REQ-033 Load mem[0]=0x0040 (mvi R0), mem[1]=0x0005, mem[2]=0x01C0 (halt); Start; Done=1 in the cycle after Run -> DIN 0x0040 with Run=1, then 0x0005 with Run=0, then Halted=1, PC=2, InstrCount=1.
REQ-034 Load mem[0]=0x00C8 (sub R1,R0), mem[1]=0x01C0; Done asserted 3 cycles after Run -> single Run pulse, DIN=0x00C8 held through WAIT, then Halted=1, InstrCount=1.
REQ-035 Load mem[0]=0x0001 (mv R0,R1); Done never asserted -> Error=1 exactly TIMEOUT (16) cycles after WAIT entry, Run=0 throughout WAIT.
REQ-036 Reset=1 during WAIT -> next cycle Busy=0, Run=0, DIN=0, PC=0, InstrCount=0; mem[0] content unchanged on readback.
REQ-037 Fill all 32 words with 0x0001, Done returned every instruction -> PC wraps 31->0, InstrCount reaches 255 and stays 255.
REQ-038 LoadEn=1, LoadAddr=0, LoadData=0x01C0 while Busy=1 -> memory unchanged; same write in HALT -> takes effect; Start mid-program ignored (PC sequence unchanged).
